// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers used by the round datapath and sequencer.
package aes_pkg;

    localparam int AES_NB     = 4;
    localparam int AES_NK_192 = 6;
    localparam int AES_NR_192 = 12;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_round_core.sv
// Combinational AES round: SubBytes -> ShiftRows -> MixColumns (skipped on final) -> AddRoundKey.
module aes_round_core
    import aes_pkg::*;
(
    input  block_t state_in,
    input  block_t round_key,
    input  logic   final_round,
    output block_t state_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];
    logic [7:0] a0, a1, a2, a3;

    // Byte i sits at row i%4, column i/4; byte 0 is the MSB of the block.
    always_comb begin
        a0 = 8'h00;
        a1 = 8'h00;
        a2 = 8'h00;
        a3 = 8'h00;
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state_in[127-8*i -: 8]);
        end
        for (int i = 0; i < 16; i++) begin
            sr[i] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int i = 0; i < 16; i++) begin
            state_out[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes192_round_sequencer.sv
// Iterative AES-192 encryption sequencer around one aes_round_core; owns state, round counter and FSM.
// Optional AES_SEQ_ABORT_EN adds an abort input that drops the in-flight block.
module aes192_round_sequencer
    import aes_pkg::*;
#(
    parameter int NB    = AES_NB,
    parameter int NK    = AES_NK_192,
    parameter int NR    = NK + 6,
    parameter int IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*NB-1:0]    plain_text,
    input  logic                key_valid,
    output logic                key_busy,
    output logic [IDX_W-1:0]    rk_idx,
    input  logic [32*NB-1:0]    rk,
    output logic                out_valid,
    input  logic                out_ready,
`ifdef AES_SEQ_ABORT_EN
    input  logic                abort,
`endif
    output logic [32*NB-1:0]    cipher_text
);

    seq_state_e         fsm_q;
    logic [32*NB-1:0]   state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic               last_round;
    logic               accept;
    logic               abort_hit;
    block_t             round_out;

`ifdef AES_SEQ_ABORT_EN
    assign abort_hit = abort && (fsm_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign last_round = (cnt_q == IDX_W'(NR));

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (fsm_q)
                IDLE:    in_ready = key_valid;
                DONE:    in_ready = key_valid && out_ready && !abort_hit;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    aes_round_core u_round_core (
        .state_in    (state_q),
        .round_key   (rk),
        .final_round (last_round),
        .state_out   (round_out)
    );

    // cnt_q is zero outside ROUND, so rk_idx selects the whitening key whenever a block can be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
        end else if (abort_hit) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q <= plain_text ^ rk;
                        cnt_q   <= IDX_W'(1);
                        fsm_q   <= ROUND;
                    end else if (fsm_q == DONE && out_ready) begin
                        fsm_q <= IDLE;
                    end
                end
                ROUND: begin
                    state_q <= round_out;
                    if (last_round) begin
                        cnt_q <= '0;
                        fsm_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign rk_idx      = cnt_q;
    assign key_busy    = (fsm_q == ROUND);
    assign out_valid   = (fsm_q == DONE);
    assign cipher_text = state_q;

endmodule

// File: tb/tb_aes192_round_sequencer.sv
// Testbench for aes192_round_sequencer: acts as key store and checks against a byte-level AES model.
module tb_aes192_round_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plain_text;
    logic         key_valid;
    logic         key_busy;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cipher_text;
`ifdef AES_SEQ_ABORT_EN
    logic         abort;
`endif

    logic [127:0] rk_tbl [0:12];
    logic [7:0]   sbox_tbl [0:255];
    int           n_pass;
    int           n_total;

    always #5 clk = ~clk;

    assign rk = (rk_idx <= 4'd12) ? rk_tbl[rk_idx] : 128'h0;

    aes192_round_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .plain_text  (plain_text),
        .key_valid   (key_valid),
        .key_busy    (key_busy),
        .rk_idx      (rk_idx),
        .rk          (rk),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef AES_SEQ_ABORT_EN
        .abort       (abort),
`endif
        .cipher_text (cipher_text)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int aa;
        p  = 0;
        aa = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
        end
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            end
            for (int i = 0; i < 8; i++) begin
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_tbl[x] = b;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
    endfunction

    task automatic load_key(input logic [191:0] key);
        logic [31:0] w [0:51];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = mul(rc, 8'h02);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int r = 0; r < 13; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tbl[0][127-8*i -: 8];
        for (int rnd = 1; rnd <= 12; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_tbl[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[(i%4) + 4*(((i/4) + (i%4)) % 4)];
            if (rnd < 12) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                    for (int j = 0; j < 4; j++)
                        s[4*c+j] = mul(8'h02, a[j]) ^ mul(8'h03, a[(j+1)%4]) ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tbl[rnd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_block(input logic [127:0] pt);
        bit ok;
        ok = 1'b0;
        plain_text = pt;
        in_valid   = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            #1;
            if (in_ready) ok = 1'b1;
            step();
        end
        in_valid   = 1'b0;
        plain_text = {$urandom, $urandom, $urandom, $urandom};
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL accept_timeout: in_ready=%b, required 1 within 40 cycles", in_ready);
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            step();
            edges++;
        end
    endtask

    function automatic logic [191:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (key_busy !== 1'b0) $display("FAIL reset_key_busy: got %b want 0", key_busy); else n_pass++;
        n_total++; if (rk_idx !== 4'd0) $display("FAIL reset_rk_idx: got %0d want 0", rk_idx); else n_pass++;
        n_total++; if (cipher_text !== 128'h0) $display("FAIL reset_cipher: got %h want 0", cipher_text); else n_pass++;
        rst_n = 1'b1;
        step();
        n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_fips();
        load_key(192'h000102030405060708090a0b0c0d0e0f1011121314151617);
        n_total++; if (rk_idx !== 4'd0) $display("FAIL fips_rk_idx_accept: got %0d want 0", rk_idx); else n_pass++;
        accept_block(128'h00112233445566778899aabbccddeeff);
        for (int k = 1; k <= 12; k++) begin
            n_total++; if (rk_idx !== 4'(k)) $display("FAIL fips_rk_idx: got %0d want %0d", rk_idx, k); else n_pass++;
            n_total++; if (key_busy !== 1'b1) $display("FAIL fips_key_busy round %0d: got %b want 1", k, key_busy); else n_pass++;
            n_total++; if (out_valid !== 1'b0) $display("FAIL fips_early_out round %0d: got %b want 0", k, out_valid); else n_pass++;
            step();
        end
        n_total++; if (out_valid !== 1'b1) $display("FAIL fips_latency: out_valid=%b want 1 after 12 edges", out_valid); else n_pass++;
        n_total++; if (key_busy !== 1'b0) $display("FAIL fips_busy_done: got %b want 0", key_busy); else n_pass++;
        n_total++; if (cipher_text !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191)
            $display("FAIL fips_ct: got %h want dda97ca4864cdfe06eaf70a0ec0d7191", cipher_text); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL fips_out_drop: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic [127:0] pt;
        logic [127:0] exp;
        int e;
        for (int n = 0; n < 6; n++) begin
            load_key(rand_key());
            pt  = {$urandom, $urandom, $urandom, $urandom};
            exp = model_encrypt(pt);
            accept_block(pt);
            wait_out(e);
            n_total++; if (e !== 12) $display("FAIL rand_latency: got %0d edges want 12", e); else n_pass++;
            n_total++; if (cipher_text !== exp) $display("FAIL rand_ct: got %h want %h", cipher_text, exp); else n_pass++;
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt;
        logic [127:0] exp;
        int e;
        load_key(rand_key());
        pt  = {$urandom, $urandom, $urandom, $urandom};
        exp = model_encrypt(pt);
        out_ready = 1'b0;
        accept_block(pt);
        wait_out(e);
        in_valid   = 1'b1;
        plain_text = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 5; k++) begin
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", out_valid); else n_pass++;
            n_total++; if (cipher_text !== exp) $display("FAIL bp_ct_stable: got %h want %h", cipher_text, exp); else n_pass++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_handshake: out_valid=%b want 0", out_valid); else n_pass++;
        n_total++; if (key_busy !== 1'b0) $display("FAIL bp_no_accept: key_busy=%b want 0", key_busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] pa, pb;
        int e;
        load_key(rand_key());
        pa = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        accept_block(pa);
        wait_out(e);
        n_total++; if (cipher_text !== model_encrypt(pa)) $display("FAIL b2b_ct_a: got %h want %h", cipher_text, model_encrypt(pa)); else n_pass++;
        in_valid   = 1'b1;
        plain_text = pb;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if (key_busy !== 1'b1) $display("FAIL b2b_no_bubble: key_busy=%b want 1", key_busy); else n_pass++;
        wait_out(e);
        n_total++; if (e + 1 !== 13) $display("FAIL b2b_spacing: got %0d cycles want 13", e + 1); else n_pass++;
        n_total++; if (cipher_text !== model_encrypt(pb)) $display("FAIL b2b_ct_b: got %h want %h", cipher_text, model_encrypt(pb)); else n_pass++;
        step();
    endtask

    task automatic test_key_valid();
        logic [127:0] pc;
        int e;
        load_key(rand_key());
        pc = {$urandom, $urandom, $urandom, $urandom};
        key_valid  = 1'b0;
        in_valid   = 1'b1;
        plain_text = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++; if (in_ready !== 1'b0) $display("FAIL kv_in_ready: got %b want 0", in_ready); else n_pass++;
            step();
            n_total++; if (key_busy !== 1'b0) $display("FAIL kv_no_accept: key_busy=%b want 0", key_busy); else n_pass++;
        end
        plain_text = pc;
        key_valid  = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL kv_raise: in_ready=%b want 1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if (key_busy !== 1'b1) $display("FAIL kv_accept: key_busy=%b want 1", key_busy); else n_pass++;
        wait_out(e);
        n_total++; if (cipher_text !== model_encrypt(pc)) $display("FAIL kv_ct: got %h want %h", cipher_text, model_encrypt(pc)); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        logic [127:0] pe;
        int e;
        load_key(rand_key());
        accept_block({$urandom, $urandom, $urandom, $urandom});
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (key_busy !== 1'b0) $display("FAIL rmid_key_busy: got %b want 0", key_busy); else n_pass++;
        n_total++; if (rk_idx !== 4'd0) $display("FAIL rmid_rk_idx: got %0d want 0", rk_idx); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        pe = {$urandom, $urandom, $urandom, $urandom};
        accept_block(pe);
        wait_out(e);
        n_total++; if (e !== 12) $display("FAIL rmid_latency: got %0d edges want 12", e); else n_pass++;
        n_total++; if (cipher_text !== model_encrypt(pe)) $display("FAIL rmid_ct: got %h want %h", cipher_text, model_encrypt(pe)); else n_pass++;
        step();
    endtask

`ifdef AES_SEQ_ABORT_EN
    task automatic test_abort();
        logic [127:0] pf;
        int e;
        load_key(rand_key());
        abort = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL abort_idle_ignored: in_ready=%b want 1", in_ready); else n_pass++;
        step();
        abort = 1'b0;
        accept_block({$urandom, $urandom, $urandom, $urandom});
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_total++; if (key_busy !== 1'b0) $display("FAIL abort_round_busy: got %b want 0", key_busy); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL abort_round_out: got %b want 0", out_valid); else n_pass++;
        n_total++; if (rk_idx !== 4'd0) $display("FAIL abort_round_idx: got %0d want 0", rk_idx); else n_pass++;
        accept_block({$urandom, $urandom, $urandom, $urandom});
        wait_out(e);
        abort      = 1'b1;
        in_valid   = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL abort_done_in_ready: got %b want 0", in_ready); else n_pass++;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL abort_done_out: got %b want 0", out_valid); else n_pass++;
        n_total++; if (key_busy !== 1'b0) $display("FAIL abort_done_busy: got %b want 0", key_busy); else n_pass++;
        pf = {$urandom, $urandom, $urandom, $urandom};
        accept_block(pf);
        wait_out(e);
        n_total++; if (cipher_text !== model_encrypt(pf)) $display("FAIL abort_next_ct: got %h want %h", cipher_text, model_encrypt(pf)); else n_pass++;
        step();
    endtask
`endif

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        key_valid  = 1'b1;
        out_ready  = 1'b1;
        plain_text = 128'h0;
`ifdef AES_SEQ_ABORT_EN
        abort      = 1'b0;
`endif
        for (int r = 0; r < 13; r++) rk_tbl[r] = 128'h0;
        build_sbox();
        #1;
        test_reset();
        test_fips();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_key_valid();
        test_reset_mid();
`ifdef AES_SEQ_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
